// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared types and constants for the EX->WB register and the
//               write-back register file (data/address types, array depth,
//               retired-write counter width).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADRS_W_DEF = 4;

  typedef logic [DATA_W_DEF-1:0] t_data;
  typedef logic [ADRS_W_DEF-1:0] t_RFadrs;

  localparam int RF_DEPTH = 2 ** ADRS_W_DEF;
  localparam int WBCNT_W  = 16;

endpackage : wb_regfile_pkg
`default_nettype wire

// File: rtl/wb_regfile_rf_array.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_rf_array
// Description : rf_array storage for the write-back register file.
//               2**ADRS_W x DATA_W flops, one synchronous write port, two
//               independent combinational read ports, asynchronous clear.
// Ports       : clock        - rising-edge clock
//               reset_n      - asynchronous active-low clear of all entries
//               i_wr_en      - write enable
//               i_wr_adrs    - write address
//               i_wr_data    - write data
//               i_rd_adrs_a  - read port A address
//               i_rd_adrs_b  - read port B address
//               o_rd_data_a  - read port A data (array contents only)
//               o_rd_data_b  - read port B data (array contents only)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_rf_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADRS_W = ADRS_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [ADRS_W-1:0] i_wr_adrs,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADRS_W-1:0] i_rd_adrs_a,
  input  logic [ADRS_W-1:0] i_rd_adrs_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b
);

  localparam int DEPTH = 2 ** ADRS_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Every entry is cleared on reset so reads are deterministic straight
  // out of reset; there is no hard-wired zero register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_adrs] <= i_wr_data;
    end
  end

  assign o_rd_data_a = r_mem[i_rd_adrs_a];
  assign o_rd_data_b = r_mem[i_rd_adrs_b];

endmodule : wb_regfile_rf_array
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage register file. Commits qualified writes
//               from the EX->WB register into the array, serves two decode
//               read ports, tracks a saturating retired-write count and the
//               destination of the most recent committed write.
//               Optional feature macro: WB_BYPASS_EN - when defined, a
//               same-cycle write to the address a read port is looking at is
//               forwarded to that port; when undefined the port returns the
//               old array value and decode must stall one cycle.
// Ports       : clock          - rising-edge clock
//               reset_n        - asynchronous active-low reset
//               wr_enx2        - write enable (EX->WB)
//               dstx2          - write destination (EX->WB)
//               dataoutx2      - write data (EX->WB)
//               rd_adrs_a/b    - read port addresses
//               rd_data_a/b    - read port data
//               wb_last_valid  - a write has committed since reset
//               wb_last_dst    - destination of the most recent commit
//               wb_count       - committed writes, saturating at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADRS_W = ADRS_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_enx2,
  input  logic [ADRS_W-1:0]  dstx2,
  input  logic [DATA_W-1:0]  dataoutx2,
  input  logic [ADRS_W-1:0]  rd_adrs_a,
  input  logic [ADRS_W-1:0]  rd_adrs_b,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  output logic               wb_last_valid,
  output logic [ADRS_W-1:0]  wb_last_dst,
  output logic [WBCNT_W-1:0] wb_count
);

  localparam logic [WBCNT_W-1:0] c_cnt_max = {WBCNT_W{1'b1}};

  logic [DATA_W-1:0]  w_arr_a;
  logic [DATA_W-1:0]  w_arr_b;
  logic               r_last_valid;
  logic [ADRS_W-1:0]  r_last_dst;
  logic [WBCNT_W-1:0] r_count;

  wb_regfile_rf_array #(
    .DATA_W (DATA_W),
    .ADRS_W (ADRS_W)
  ) u_rf_array (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_wr_en     (wr_enx2),
    .i_wr_adrs   (dstx2),
    .i_wr_data   (dataoutx2),
    .i_rd_adrs_a (rd_adrs_a),
    .i_rd_adrs_b (rd_adrs_b),
    .o_rd_data_a (w_arr_a),
    .o_rd_data_b (w_arr_b)
  );

`ifdef WB_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  // Forward the in-flight write so decode sees it with zero latency.
  assign w_hit_a   = wr_enx2 && (dstx2 == rd_adrs_a);
  assign w_hit_b   = wr_enx2 && (dstx2 == rd_adrs_b);
  assign rd_data_a = w_hit_a ? dataoutx2 : w_arr_a;
  assign rd_data_b = w_hit_b ? dataoutx2 : w_arr_b;
`else
  assign rd_data_a = w_arr_a;
  assign rd_data_b = w_arr_b;
`endif

  // Commit side-effects share the write edge; the counter sticks at
  // all-ones rather than wrapping so debug never sees a bogus small count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_valid <= 1'b0;
      r_last_dst   <= '0;
      r_count      <= '0;
    end else if (wr_enx2) begin
      r_last_valid <= 1'b1;
      r_last_dst   <= dstx2;
      if (r_count != c_cnt_max) begin
        r_count <= r_count + WBCNT_W'(1);
      end
    end
  end

  assign wb_last_valid = r_last_valid;
  assign wb_last_dst   = r_last_dst;
  assign wb_count      = r_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking directed testbench for wb_regfile. Expected
//               values are hand-computed constants; build with or without
//               WB_BYPASS_EN to match the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

  logic        clock;
  logic        reset_n;
  logic        wr_enx2;
  logic [3:0]  dstx2;
  logic [7:0]  dataoutx2;
  logic [3:0]  rd_adrs_a;
  logic [3:0]  rd_adrs_b;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic        wb_last_valid;
  logic [3:0]  wb_last_dst;
  logic [15:0] wb_count;

  int n_checks;
  int n_errors;

`ifdef WB_BYPASS_EN
  localparam logic [7:0] c_hazard_exp = 8'h22;
`else
  localparam logic [7:0] c_hazard_exp = 8'h11;
`endif

  wb_regfile u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_enx2       (wr_enx2),
    .dstx2         (dstx2),
    .dataoutx2     (dataoutx2),
    .rd_adrs_a     (rd_adrs_a),
    .rd_adrs_b     (rd_adrs_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .wb_last_valid (wb_last_valid),
    .wb_last_dst   (wb_last_dst),
    .wb_count      (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input logic [7:0] v);
    wr_enx2   = 1'b1;
    dstx2     = d;
    dataoutx2 = v;
    step();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    wr_enx2   = 1'b1;
    dstx2     = 4'd3;
    dataoutx2 = 8'hAA;
    rd_adrs_a = 4'd3;
    rd_adrs_b = 4'd3;

    // Reset with a write presented: the write must be dropped.
    step();
    step();
    chk("rst_cnt_in_reset", 32'(wb_count), 32'h0);
    wr_enx2 = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("rst_rd_a", 32'(rd_data_a), 32'h0);
    chk("rst_rd_b", 32'(rd_data_b), 32'h0);
    chk("rst_cnt", 32'(wb_count), 32'h0);
    chk("rst_valid", 32'(wb_last_valid), 32'h0);
    chk("rst_dst", 32'(wb_last_dst), 32'h0);
    step();
    chk("rst_rd_a_after_edge", 32'(rd_data_a), 32'h0);

    // Basic write/read.
    wr(4'd7, 8'h5C);
    wr_enx2   = 1'b0;
    rd_adrs_a = 4'd7;
    rd_adrs_b = 4'd3;
    #1;
    chk("basic_rd_a", 32'(rd_data_a), 32'h5C);
    chk("basic_rd_b_other", 32'(rd_data_b), 32'h0);
    chk("basic_cnt", 32'(wb_count), 32'd1);
    chk("basic_dst", 32'(wb_last_dst), 32'd7);
    chk("basic_valid", 32'(wb_last_valid), 32'd1);

    // Same-cycle hazard on r2.
    wr(4'd2, 8'h11);
    wr_enx2   = 1'b1;
    dstx2     = 4'd2;
    dataoutx2 = 8'h22;
    rd_adrs_a = 4'd2;
    rd_adrs_b = 4'd2;
    #1;
    chk("hazard_rd_a", 32'(rd_data_a), 32'(c_hazard_exp));
    chk("hazard_rd_b", 32'(rd_data_b), 32'(c_hazard_exp));
    step();
    wr_enx2 = 1'b0;
    #1;
    chk("hazard_next_a", 32'(rd_data_a), 32'h22);
    chk("hazard_next_b", 32'(rd_data_b), 32'h22);
    chk("hazard_cnt", 32'(wb_count), 32'd3);

    // Back-to-back writes, repeated destination takes the last value.
    wr(4'd1, 8'h01);
    wr(4'd1, 8'h02);
    wr(4'd4, 8'h03);
    wr_enx2   = 1'b0;
    rd_adrs_a = 4'd1;
    rd_adrs_b = 4'd4;
    #1;
    chk("b2b_r1", 32'(rd_data_a), 32'h02);
    chk("b2b_r4", 32'(rd_data_b), 32'h03);
    chk("b2b_cnt", 32'(wb_count), 32'd6);
    chk("b2b_dst", 32'(wb_last_dst), 32'd4);

    // Disabled write with live address/data must not change the array.
    dstx2     = 4'd1;
    dataoutx2 = 8'hEE;
    step();
    chk("noen_r1", 32'(rd_data_a), 32'h02);
    chk("noen_cnt", 32'(wb_count), 32'd6);

    // Asynchronous reset between edges.
    wr(4'd9, 8'h77);
    wr_enx2   = 1'b0;
    rd_adrs_a = 4'd9;
    #1;
    chk("pre_async_r9", 32'(rd_data_a), 32'h77);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_r9", 32'(rd_data_a), 32'h0);
    chk("async_cnt", 32'(wb_count), 32'h0);
    chk("async_valid", 32'(wb_last_valid), 32'h0);
    chk("async_dst", 32'(wb_last_dst), 32'h0);
    #1;
    reset_n = 1'b1;
    step();

    // Counter saturation: 65535 writes reach all-ones, further writes hold.
    for (int i = 0; i < 65535; i++) begin
      wr(4'(i), 8'(i));
    end
    wr_enx2 = 1'b0;
    #1;
    chk("sat_reach", 32'(wb_count), 32'hFFFF);
    wr(4'hC, 8'h3E);
    wr_enx2   = 1'b0;
    rd_adrs_a = 4'hC;
    rd_adrs_b = 4'hE;
    #1;
    chk("sat_hold", 32'(wb_count), 32'hFFFF);
    chk("sat_dst", 32'(wb_last_dst), 32'hC);
    chk("sat_rd_c", 32'(rd_data_a), 32'h3E);
    // Last write to r14 was i=65534 -> data 8'hFE.
    chk("sat_rd_e", 32'(rd_data_b), 32'hFE);
    wr(4'h0, 8'h55);
    wr_enx2 = 1'b0;
    #1;
    chk("sat_hold2", 32'(wb_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wb_regfile
`default_nettype wire
